// File: rtl/spi_frame_rx_pkg.sv
// Shared types and mode-decode helpers for the oversampling SPI frame receiver.
package spi_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } rx_state_t;

  // Counter must reach 8*NBYTES+1 so that over-long frames stay distinguishable.
  function automatic int BITCNT_W(input int nbytes);
    return $clog2(8 * nbytes + 2);
  endfunction

  function automatic bit sample_rising(input bit cpol, input bit cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// Frame hand-off bundle between the SPI receiver (master) and the command decoder (slave).
interface spi_frame_rx_if #(
  parameter int NBYTES = 3
);

  logic [8*NBYTES-1:0] frame_data;
  logic                frame_valid;
  logic                frame_ready;
  logic                frame_err;
  logic                overrun;

  modport master (
    output frame_data,
    output frame_valid,
    output frame_err,
    output overrun,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    input  frame_err,
    input  overrun,
    output frame_ready
  );

endinterface

// File: rtl/spi_frame_rx_sync2.sv
// Two-flop synchroniser bank for asynchronous pin inputs; clears to zero on reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampled SPI frame receiver: assembles NBYTES-byte frames from the pins and
// hands them to the consumer through a valid/ready holding register.
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int NBYTES    = 3,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          sck,
  input  logic          cs,
  input  logic          sdi,
  spi_frame_rx_if.master frm
);

  localparam int FW = 8 * NBYTES;
  localparam int CW = BITCNT_W(NBYTES);
  localparam bit SAMPLE_RISING = sample_rising(CPOL, CPHA);
  localparam logic [CW-1:0] CNT_FULL = CW'(FW);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

  logic [2:0] pins_s;
  logic       sck_s, cs_s, sdi_s;

  sync2 #(.W(3)) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d_i    ({sck, cs, sdi}),
    .q_o    (pins_s)
  );

  assign sck_s = pins_s[2];
  assign cs_s  = pins_s[1];
  assign sdi_s = pins_s[0];

  rx_state_t     state_q;
  logic [1:0]    arm_cnt_q;
  logic          sck_d_q, cs_d_q;
  logic [CW-1:0] cnt_q;
  logic [FW-1:0] shift_q, data_q;
  logic          valid_q, err_q, ovr_q;

  logic sample_d, cs_rise_d, cs_fall_d;
  logic [FW-1:0] frame_ord_d;

  assign sample_d  = SAMPLE_RISING ? (sck_s & ~sck_d_q) : (~sck_s & sck_d_q);
  assign cs_rise_d = cs_s & ~cs_d_q;
  assign cs_fall_d = ~cs_s & cs_d_q;

  // LSB-first links arrive bit-reversed within each byte; byte order is kept.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    for (genvar gb = 0; gb < 8; gb++) begin : g_bit
      assign frame_ord_d[8*gi+gb] = MSB_FIRST ? shift_q[8*gi+gb] : shift_q[8*gi+7-gb];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ARM;
      arm_cnt_q <= '0;
      sck_d_q   <= 1'b0;
      cs_d_q    <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sck_d_q <= sck_s;
      cs_d_q  <= cs_s;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      if (valid_q && frm.frame_ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        ARM: begin
          // Synchroniser outputs read 0 until flushed, so wait before trusting cs low.
          if (arm_cnt_q != 2'd3) begin
            arm_cnt_q <= arm_cnt_q + 2'd1;
          end else if (!cs_s) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (cs_rise_d) begin
            cnt_q   <= '0;
            shift_q <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_fall_d) begin
            state_q <= IDLE;
            if (cnt_q == CNT_FULL) begin
              if (!valid_q || frm.frame_ready) begin
                data_q  <= frame_ord_d;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else if (cnt_q != '0) begin
              err_q <= 1'b1;
            end
          end else if (sample_d) begin
            shift_q <= {shift_q[FW-2:0], sdi_s};
            if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ARM;
      endcase
    end
  end

  assign frm.frame_data  = data_q;
  assign frm.frame_valid = valid_q;
  assign frm.frame_err   = err_q;
  assign frm.overrun     = ovr_q;

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

Parametrised, clock-domain-safe SPI frame receiver. It oversamples `sck`, `cs` and `sdi` on the system clock. It assembles a fixed-length frame of `NBYTES` bytes and presents it through a valid/ready holding register. Short and long frames are reported and discarded, and frames that arrive while the holding register is full are counted as overruns. It sits between the MCU's SPI pins and the command decoder, replacing the sck-clocked 3-byte shift register.

## Interface
- `NBYTES`, default 3: bytes per frame, 1–8.
- `CPOL`, default 0: sck idle level.
- `CPHA`, default 0: 0 = sample on the leading edge, 1 = sample on the trailing edge.
- `MSB_FIRST`, default 1: bit order within each byte.
- `clk` input 1: system clock. This is the only clock in the block.
- `nreset` input 1: asynchronous, active-low reset.
- `sck` input 1: SPI clock, asynchronous to `clk`.
- `cs` input 1: chip select, active-high (high = frame in progress).
- `sdi` input 1: SPI serial data in.
- `frame_data` output 8*NBYTES: last good frame. The first received byte occupies bits [8*NBYTES-1 -: 8].
- `frame_valid` output 1: `frame_data` holds an unconsumed frame.
- `frame_ready` input 1: consumer accepts the frame on a clk edge where valid && ready.
- `frame_err` output 1: one-cycle pulse; the frame length was not exactly 8*NBYTES bits.
- `overrun` output 1: one-cycle pulse; a good frame was dropped because the holding register was full.

## Operation
- `sck`, `cs` and `sdi` each pass through a 2-flop synchroniser. A third flop on `sck` and `cs` provides edge detection.
- Sample edge:
  - rising `sck` when CPOL == CPHA;
  - falling `sck` otherwise.
  - The opposite edge is ignored; there is no transmit path.
- States:
  - ARM: entered on reset. Moves to IDLE once synchronised `cs` is seen low for one clk cycle. A frame in progress at reset is discarded silently.
  - IDLE: a `cs` rising edge clears the bit counter and shift register and moves to SHIFT.
  - SHIFT: on each sample edge, shift `sdi` in and increment the bit counter.
    - The counter saturates at 8*NBYTES+1.
    - A `cs` falling edge moves to IDLE and evaluates the frame.
- Frame evaluation on `cs` fall:
  - 0 bits: ignored; no pulse, no state change (cs glitch).
  - Exactly 8*NBYTES bits: good frame.
    - If `frame_valid` is low, or `frame_ready` is high in the same cycle, load `frame_data` and set `frame_valid`.
    - Otherwise pulse `overrun` and keep the old data.
  - Any other count (including saturated): pulse `frame_err`; `frame_data` and `frame_valid` are unchanged.
- Bit order:
  - MSB_FIRST = 1: each byte is assembled MSB-first, and the whole frame is one left shift.
  - MSB_FIRST = 0: each byte is reversed as it completes, and byte order is preserved.
- `frame_valid` clears on valid && ready unless a good frame loads in the same cycle. In that case it stays high with the new data.
- Reset values: `frame_data` = 0, `frame_valid` = 0, `frame_err` = 0, `overrun` = 0, state = ARM, synchronisers = 0.

## Timing
- `sck` high and low phases must each be ≥ 3 clk periods.
- `cs` setup to the first sample edge must be ≥ 3 clk periods, and hold after the last sample edge ≥ 3 clk periods.
- `sdi` must be stable ≥ 3 clk periods around each sample edge.
- Latency: a pin-level sample edge is registered into the shift register on the 3rd clk rising edge after it.
- A `cs` fall updates `frame_valid`, `frame_err` and `overrun` on the 3rd clk edge after it.
- `frame_err` and `overrun` are high for exactly one clk cycle.
- Back-to-back frames need ≥ 3 clk periods of `cs` low.
- `nreset` assertion takes effect immediately on all outputs. The block resumes at the first clk edge after deassertion.

## Structure
- Package `spi_pkg` holds:
  - `rx_state_t` enum {ARM, IDLE, SHIFT};
  - the `BITCNT_W` function ($clog2(8*NBYTES+2));
  - localparams for mode decode (`SAMPLE_RISING` = CPOL == CPHA).
- Sub-module `sync2` (parametrised width, reset value 0) instantiates the synchronisers. Everything else lives in `spi_frame_rx`.

## Test plan
- NBYTES=3, mode 0, `frame_ready`=1: send 0x03,0x18,0x09 -> `frame_data`=0x031809; `frame_valid` high for exactly 1 cycle; no err/overrun.
- Send 23 bits, then 25 bits -> one `frame_err` pulse each; `frame_valid` stays 0; `frame_data` unchanged.
- `frame_ready`=0: send 0xA55AFF then 0x010203 -> second frame pulses `overrun`; data stays 0xA55AFF. Raising ready -> valid drops after 1 cycle.
- Instance CPOL=1, CPHA=1, MSB_FIRST=0, sck idling high: send wire bytes 0x03,0xFF,0x77 (LSB first) -> `frame_data`=0xC0FFEE.
- Assert `nreset` after 10 bits, release with `cs` still high, finish the frame -> no valid, no err. Next full frame 0x123456 is received correctly.
- Valid held with ready=0: raise ready on the same clk edge the new frame 0xABCDEF completes -> valid stays high, data=0xABCDEF, no overrun.
